// File: rtl/cpu8.sv
// cpu8: four-phase 8-bit core with internal program ROM.
// Six registers, ALU, copy, conditional jump.
module cpu8 #(
  parameter logic [2047:0] ROM_IMAGE = 2048'h9E_44_82_0A_B1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] cpuin,
  output logic [7:0] cpuout,
  output logic       dbg_fetch,
  output logic       dbg_decode,
  output logic       dbg_execute,
  output logic       dbg_writeback,
  output logic [7:0] dbg_pcout,
  output logic [7:0] dbg_romout,
  output logic [7:0] dbg_loadbus,
  output logic [7:0] dbg_savebus,
  output logic [7:0] dbg_jumptarget,
  output logic [7:0] dbg_aluopA,
  output logic [7:0] dbg_aluopB,
  output logic [7:0] dbg_aluresult
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0000,
    S_FETCH = 4'b0001,
    S_DEC   = 4'b0010,
    S_EXEC  = 4'b0100,
    S_WB    = 4'b1000
  } state_e;

  state_e     state_q;
  logic [7:0] pc_q;
  logic [7:0] ir_q;
  logic [7:0] save_q;
  logic [7:0] out_q;
  logic [7:0] regs_q [6];
  logic [1:0] cls_q;
  logic [2:0] src_q;
  logic [2:0] op_q;
  logic       take_q;

  logic [7:0] rom_w;
  logic [7:0] alu_w;
  logic [7:0] src_w;
  logic [7:0] load_w;
  logic       take_w;
  logic [7:0] pc_d;
  logic       eq_w;
  logic       neg_w;

  // Address 0 lives in the least significant byte of the image.
  assign rom_w = ROM_IMAGE[{pc_q, 3'b000} +: 8];

  always_comb begin
    alu_w = 8'h00;
    unique case (op_q)
      3'd0: alu_w = regs_q[1] | regs_q[2];
      3'd1: alu_w = ~(regs_q[1] & regs_q[2]);
      3'd2: alu_w = ~(regs_q[1] | regs_q[2]);
      3'd3: alu_w = regs_q[1] & regs_q[2];
      3'd4: alu_w = regs_q[1] + regs_q[2];
      3'd5: alu_w = regs_q[1] - regs_q[2];
      3'd6: alu_w = regs_q[1] ^ regs_q[2];
      3'd7: alu_w = ~(regs_q[1] ^ regs_q[2]);
    endcase
  end

  always_comb begin
    src_w = 8'h00;
    unique case (src_q)
      3'd0: src_w = regs_q[0];
      3'd1: src_w = regs_q[1];
      3'd2: src_w = regs_q[2];
      3'd3: src_w = regs_q[3];
      3'd4: src_w = regs_q[4];
      3'd5: src_w = regs_q[5];
      3'd6: src_w = cpuin;
      3'd7: src_w = 8'h00;
    endcase
  end

  // A jump carries its target (reg0) through the save register.
  always_comb begin
    load_w = 8'h00;
    unique case (cls_q)
      2'b00: load_w = {2'b00, ir_q[5:0]};
      2'b01: load_w = alu_w;
      2'b10: load_w = src_w;
      2'b11: load_w = regs_q[0];
    endcase
  end

  assign eq_w  = (regs_q[3] == 8'h00);
  assign neg_w = regs_q[3][7];

  always_comb begin
    take_w = 1'b0;
    unique case (op_q)
      3'd0: take_w = 1'b0;
      3'd1: take_w = eq_w;
      3'd2: take_w = neg_w;
      3'd3: take_w = neg_w | eq_w;
      3'd4: take_w = 1'b1;
      3'd5: take_w = ~eq_w;
      3'd6: take_w = ~neg_w;
      3'd7: take_w = ~neg_w & ~eq_w;
    endcase
  end

  assign pc_d = (cls_q == 2'b11 && take_q) ? save_q
                                           : pc_q + 8'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= 8'h00;
      ir_q    <= 8'h00;
      save_q  <= 8'h00;
      out_q   <= 8'h00;
      cls_q   <= 2'b00;
      src_q   <= 3'd0;
      op_q    <= 3'd0;
      take_q  <= 1'b0;
      for (int i = 0; i < 6; i++) regs_q[i] <= 8'h00;
    end else if (enable) begin
      unique case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          ir_q    <= rom_w;
        end
        S_FETCH: begin
          state_q <= S_DEC;
          cls_q   <= ir_q[7:6];
          src_q   <= ir_q[5:3];
          op_q    <= ir_q[2:0];
        end
        S_DEC: begin
          state_q <= S_EXEC;
          save_q  <= load_w;
          take_q  <= take_w;
        end
        S_EXEC: begin
          state_q <= S_WB;
          pc_q    <= pc_d;
          unique case (cls_q)
            2'b00: regs_q[0] <= save_q;
            2'b01: regs_q[3] <= save_q;
            2'b10: begin
              unique case (op_q)
                3'd0: regs_q[0] <= save_q;
                3'd1: regs_q[1] <= save_q;
                3'd2: regs_q[2] <= save_q;
                3'd3: regs_q[3] <= save_q;
                3'd4: regs_q[4] <= save_q;
                3'd5: regs_q[5] <= save_q;
                3'd6: out_q     <= save_q;
                3'd7: ;
              endcase
            end
            2'b11: ;
          endcase
        end
        S_WB: begin
          state_q <= S_FETCH;
          ir_q    <= rom_w;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpuout         = out_q;
  assign dbg_fetch      = state_q[0];
  assign dbg_decode     = state_q[1];
  assign dbg_execute    = state_q[2];
  assign dbg_writeback  = state_q[3];
  assign dbg_pcout      = pc_q;
  assign dbg_romout     = rom_w;
  assign dbg_loadbus    = load_w;
  assign dbg_savebus    = save_q;
  assign dbg_jumptarget = regs_q[0];
  assign dbg_aluopA     = regs_q[1];
  assign dbg_aluopB     = regs_q[2];
  assign dbg_aluresult  = regs_q[3];

endmodule

// File: tb/tb_cpu8.sv
// tb_cpu8: scoreboard bench for cpu8.
// Built-in program on one core, ALU/jump program on another.
module tb_cpu8;

  function automatic logic [2047:0] mk_img();
    logic [2047:0] v;
    v = '0;
    v[8*0  +: 8] = 8'hB1;
    v[8*1  +: 8] = 8'h02;
    v[8*2  +: 8] = 8'h82;
    v[8*3  +: 8] = 8'h44;
    v[8*4  +: 8] = 8'h41;
    v[8*5  +: 8] = 8'h47;
    v[8*6  +: 8] = 8'h45;
    v[8*7  +: 8] = 8'h20;
    v[8*8  +: 8] = 8'h42;
    v[8*9  +: 8] = 8'hC1;
    v[8*32 +: 8] = 8'h00;
    v[8*33 +: 8] = 8'h82;
    v[8*34 +: 8] = 8'hB1;
    v[8*35 +: 8] = 8'h40;
    v[8*36 +: 8] = 8'h20;
    v[8*37 +: 8] = 8'hC7;
    return v;
  endfunction

  localparam logic [2047:0] ALU_IMG = mk_img();

  localparam int M_PH = 0, M_PC = 1, M_OUT = 2;
  localparam int M_R0 = 3, M_R1 = 4, M_R2 = 5, M_R3 = 6;
  localparam int A_PC = 7;
  localparam int A_R0 = 8, A_R1 = 9, A_R2 = 10, A_R3 = 11;
  localparam int A_OUT = 12, M_SV = 13, M_LD = 14, M_ROM = 15;
  localparam int A_PH = 16, A_ROM = 17, A_LD = 18, A_SV = 19;

  logic       clk, rst, en;
  logic [7:0] cin_m, cin_a;

  logic       m_f, m_d, m_e, m_w;
  logic [7:0] m_out, m_pc, m_rom, m_ld, m_sv;
  logic [7:0] m_r0, m_r1, m_r2, m_r3;
  logic       a_f, a_d, a_e, a_w;
  logic [7:0] a_out, a_pc, a_rom, a_ld, a_sv;
  logic [7:0] a_r0, a_r1, a_r2, a_r3;

  cpu8 u_dut (
    .clock(clk), .reset(rst), .enable(en),
    .cpuin(cin_m), .cpuout(m_out),
    .dbg_fetch(m_f), .dbg_decode(m_d),
    .dbg_execute(m_e), .dbg_writeback(m_w),
    .dbg_pcout(m_pc), .dbg_romout(m_rom),
    .dbg_loadbus(m_ld), .dbg_savebus(m_sv),
    .dbg_jumptarget(m_r0), .dbg_aluopA(m_r1),
    .dbg_aluopB(m_r2), .dbg_aluresult(m_r3)
  );

  cpu8 #(.ROM_IMAGE(ALU_IMG)) u_alu (
    .clock(clk), .reset(rst), .enable(en),
    .cpuin(cin_a), .cpuout(a_out),
    .dbg_fetch(a_f), .dbg_decode(a_d),
    .dbg_execute(a_e), .dbg_writeback(a_w),
    .dbg_pcout(a_pc), .dbg_romout(a_rom),
    .dbg_loadbus(a_ld), .dbg_savebus(a_sv),
    .dbg_jumptarget(a_r0), .dbg_aluopA(a_r1),
    .dbg_aluopB(a_r2), .dbg_aluresult(a_r3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         sel;
    logic [7:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   b;

  function automatic logic [7:0] obs(int s);
    case (s)
      M_PH:  return {4'h0, m_w, m_e, m_d, m_f};
      M_PC:  return m_pc;
      M_OUT: return m_out;
      M_R0:  return m_r0;
      M_R1:  return m_r1;
      M_R2:  return m_r2;
      M_R3:  return m_r3;
      M_SV:  return m_sv;
      M_LD:  return m_ld;
      M_ROM: return m_rom;
      A_PH:  return {4'h0, a_w, a_e, a_d, a_f};
      A_PC:  return a_pc;
      A_R0:  return a_r0;
      A_R1:  return a_r1;
      A_R2:  return a_r2;
      A_R3:  return a_r3;
      A_OUT: return a_out;
      A_ROM: return a_rom;
      A_LD:  return a_ld;
      A_SV:  return a_sv;
      default: return 8'hxx;
    endcase
  endfunction

  task automatic chk(string tag, logic [7:0] got,
                     logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %02h want %02h", tag, got, exp);
    end
  endtask

  task automatic push(int c, int s, logic [7:0] v,
                      string t);
    exp_t e;
    e.cyc = c;
    e.sel = s;
    e.exp = v;
    e.tag = t;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.sel), e.exp);
    end
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    cin_m = 8'h00;
    cin_a = 8'hFF;
    tick();
    tick();
    rst = 1'b0;

    push(cyc + 4, M_PH,  8'h00, "idle_ph");
    push(cyc + 4, M_PC,  8'h00, "idle_pc");
    push(cyc + 4, M_OUT, 8'h00, "idle_out");
    repeat (4) tick();

    cin_m = 8'h05;
    en    = 1'b1;
    b     = cyc;
    push(b + 1,  M_PH,  8'h01, "ph_e1");
    push(b + 1,  M_ROM, 8'hB1, "rom0");
    push(b + 1,  A_PH,  8'h01, "a_ph_e1");
    push(b + 2,  M_PH,  8'h02, "ph_e2");
    push(b + 2,  M_LD,  8'h05, "ld_cpuin");
    push(b + 3,  M_PH,  8'h04, "ph_e3");
    push(b + 3,  M_SV,  8'h05, "sv_cpuin");
    push(b + 4,  M_PH,  8'h08, "ph_e4");
    push(b + 4,  M_R1,  8'h05, "r1_in");
    push(b + 4,  A_R1,  8'hFF, "a_r1_in");
    push(b + 4,  A_ROM, 8'h02, "a_rom1");
    push(b + 5,  M_PH,  8'h01, "ph_e5");
    push(b + 8,  M_R0,  8'h0A, "r0_imm");
    push(b + 8,  A_R0,  8'h02, "a_r0_imm");
    push(b + 12, M_R2,  8'h0A, "r2_copy");
    push(b + 12, A_R2,  8'h02, "a_r2_copy");
    push(b + 14, A_LD,  8'h01, "a_ld_add");
    push(b + 15, A_SV,  8'h01, "a_sv_add");
    push(b + 16, M_R3,  8'h0F, "r3_add");
    push(b + 16, M_OUT, 8'h00, "out_pre");
    push(b + 16, A_R3,  8'h01, "add_wrap");
    push(b + 20, M_OUT, 8'h0F, "out_copy");
    push(b + 20, M_R0,  8'h0A, "r0_keep");
    push(b + 20, M_R1,  8'h05, "r1_keep");
    push(b + 20, M_R2,  8'h0A, "r2_keep");
    push(b + 20, M_R3,  8'h0F, "r3_keep");
    push(b + 20, A_R3,  8'hFD, "nand");
    push(b + 24, A_R3,  8'h02, "xnor");
    push(b + 28, A_R3,  8'hFD, "sub_wrap");
    push(b + 32, A_R0,  8'h20, "a_r0_tgt");
    push(b + 36, A_R3,  8'h00, "nor");
    push(b + 36, A_PC,  8'h09, "pc_seq");
    push(b + 40, A_PC,  8'h20, "jmp_eq0");
    push(b + 52, A_R1,  8'h80, "a_r1_neg");
    push(b + 56, A_R3,  8'h80, "or_neg");
    push(b + 60, A_R0,  8'h20, "a_r0_tgt2");
    push(b + 60, A_PC,  8'h25, "pc_pre_jmp");
    push(b + 64, A_PC,  8'h26, "jmp_gt0_nt");
    push(b + 64, A_OUT, 8'h00, "a_out_idle");
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i == 40) cin_a = 8'h80;
    end

    rst = 1'b1;
    push(cyc + 1, M_PH,  8'h00, "rst_en_ph");
    push(cyc + 1, M_PC,  8'h00, "rst_pc");
    push(cyc + 1, M_OUT, 8'h00, "rst_out");
    tick();
    rst   = 1'b0;
    cin_m = 8'h33;
    push(cyc + 3, M_PH, 8'h04, "frz_exec");
    repeat (3) tick();

    en    = 1'b0;
    cin_m = 8'h77;
    push(cyc + 3, M_PH, 8'h04, "frz_ph");
    push(cyc + 3, M_R1, 8'h00, "frz_r1");
    push(cyc + 3, M_PC, 8'h00, "frz_pc");
    push(cyc + 3, M_SV, 8'h33, "frz_sv");
    repeat (3) tick();

    en = 1'b1;
    push(cyc + 1, M_PH, 8'h08, "resume_wb");
    push(cyc + 1, M_R1, 8'h33, "resume_r1");
    push(cyc + 1, M_PC, 8'h01, "resume_pc");
    push(cyc + 2, M_PH, 8'h01, "resume_f");
    push(cyc + 3, M_PH, 8'h02, "resume_d");
    repeat (3) tick();

    rst = 1'b1;
    push(cyc + 1, M_PH,  8'h00, "abort_ph");
    push(cyc + 1, M_PC,  8'h00, "abort_pc");
    push(cyc + 1, M_OUT, 8'h00, "abort_out");
    push(cyc + 1, M_R0,  8'h00, "abort_r0");
    push(cyc + 1, M_R1,  8'h00, "abort_r1");
    tick();
    rst = 1'b0;
    push(cyc + 1, M_PH, 8'h01, "restart");
    tick();

    chk("sb_left", 8'(sb.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
